// File: rtl/asrv32_lsu_pkg.sv
// rtl/asrv32_lsu_pkg.sv - shared LSU state encoding, width codes and byte-mask constants
package asrv32_lsu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_DONE  = 2'd2,
        ST_FAULT = 2'd3
    } lsu_state_e;

    localparam logic [1:0] W_BYTE   = 2'b00;
    localparam logic [1:0] W_HALF   = 2'b01;
    localparam logic [1:0] W_WORD   = 2'b10;
    localparam logic [1:0] W_DOUBLE = 2'b11;

    localparam logic [7:0] MASK_BYTE   = 8'h01;
    localparam logic [7:0] MASK_HALF   = 8'h03;
    localparam logic [7:0] MASK_WORD   = 8'h0F;
    localparam logic [7:0] MASK_DOUBLE = 8'hFF;

    function automatic logic [7:0] size_mask(input logic [1:0] w);
        case (w)
            W_BYTE:  return MASK_BYTE;
            W_HALF:  return MASK_HALF;
            W_WORD:  return MASK_WORD;
            default: return MASK_DOUBLE;
        endcase
    endfunction

endpackage

// File: rtl/asrv32_lsu_if.sv
// rtl/asrv32_lsu_if.sv - LSU to memory request/response bus
interface asrv32_lsu_if #(
    parameter int XLEN = 32
);
    localparam int NBYTES = XLEN / 8;

    logic              o_mem_req;
    logic              o_mem_we;
    logic [XLEN-1:0]   o_mem_addr;
    logic [XLEN-1:0]   o_mem_wdata;
    logic [NBYTES-1:0] o_mem_wmask;
    logic              i_mem_ack;
    logic [XLEN-1:0]   i_mem_rdata;

    modport master (
        output o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_wmask,
        input  i_mem_ack, i_mem_rdata
    );

    modport slave (
        input  o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_wmask,
        output i_mem_ack, i_mem_rdata
    );

endinterface

// File: rtl/asrv32_lsu_align.sv
// rtl/asrv32_lsu_align.sv - lane alignment: store mask/data shift, load extract/extend, misalignment
module asrv32_lsu_align
    import asrv32_lsu_pkg::*;
#(
    parameter  int XLEN      = 32,
    localparam int NBYTES    = XLEN / 8,
    localparam int LANE_BITS = $clog2(NBYTES)
) (
    input  logic [2:0]           i_funct3,
    input  logic [LANE_BITS-1:0] i_lane,
    input  logic [XLEN-1:0]      i_rs2,
    input  logic [XLEN-1:0]      i_rdata,
    output logic [NBYTES-1:0]    o_wmask,
    output logic [XLEN-1:0]      o_wdata,
    output logic [XLEN-1:0]      o_load_data,
    output logic                 o_misaligned
);

    logic [1:0]      w;
    logic [3:0]      lane_ext;
    logic [3:0]      align_bits;
    logic [15:0]     mask_sh;
    logic [XLEN-1:0] shifted;
    logic [XLEN-1:0] keep;
    logic [6:0]      nbits;
    logic            sbit;

    assign w = i_funct3[1:0];

    always_comb begin
        lane_ext     = 4'(i_lane);
        align_bits   = (4'd1 << w) - 4'd1;
        o_misaligned = |(lane_ext & align_bits);

        mask_sh = {8'h00, size_mask(w)} << i_lane;
        o_wmask = mask_sh[NBYTES-1:0];
        o_wdata = i_rs2 << {i_lane, 3'b000};

        // keep covers the accessed bytes; a shift of nbits >= XLEN leaves all ones
        shifted = i_rdata >> {i_lane, 3'b000};
        nbits   = 7'd8 << w;
        keep    = ~({XLEN{1'b1}} << nbits);
        case (w)
            W_BYTE:  sbit = shifted[7];
            W_HALF:  sbit = shifted[15];
            W_WORD:  sbit = shifted[31];
            default: sbit = shifted[XLEN-1];
        endcase
        o_load_data = (shifted & keep) | (~keep & {XLEN{sbit & ~i_funct3[2]}});
    end

endmodule

// File: rtl/asrv32_lsu.sv
// rtl/asrv32_lsu.sv - single-outstanding load/store unit with fault detection and ack timeout
module asrv32_lsu
    import asrv32_lsu_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_start,
    input  logic            i_is_store,
    input  logic [2:0]      i_funct3,
    input  logic [XLEN-1:0] i_addr,
    input  logic [XLEN-1:0] i_rs2_data,
    output logic            o_busy,
    output logic            o_done,
    output logic [XLEN-1:0] o_load_data,
    output logic            o_misaligned,
    output logic            o_illegal,
    output logic            o_timeout,
    asrv32_lsu_if.master    mem
);

    localparam int          NBYTES    = XLEN / 8;
    localparam int          LANE_BITS = $clog2(NBYTES);
    localparam logic [15:0] CNT_LAST  = 16'(TIMEOUT_CYCLES - 1);

    lsu_state_e           state_q, state_d;
    logic [15:0]          cnt_q, cnt_d;
    logic                 is_store_q, is_store_d;
    logic [2:0]           funct3_q, funct3_d;
    logic [LANE_BITS-1:0] lane_q, lane_d;
    logic                 mem_req_q, mem_req_d;
    logic                 mem_we_q, mem_we_d;
    logic [XLEN-1:0]      mem_addr_q, mem_addr_d;
    logic [XLEN-1:0]      mem_wdata_q, mem_wdata_d;
    logic [NBYTES-1:0]    mem_wmask_q, mem_wmask_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 mis_q, mis_d;
    logic                 ill_q, ill_d;
    logic                 tmo_q, tmo_d;
    logic [XLEN-1:0]      load_data_q, load_data_d;

    logic [2:0]           a_funct3;
    logic [LANE_BITS-1:0] a_lane;
    logic [NBYTES-1:0]    a_wmask;
    logic [XLEN-1:0]      a_wdata;
    logic [XLEN-1:0]      a_load;
    logic                 a_mis;
    logic                 illegal;

    // IDLE aligns the incoming request; REQ reuses the captured size/lane for the load return
    assign a_funct3 = (state_q == ST_IDLE) ? i_funct3 : funct3_q;
    assign a_lane   = (state_q == ST_IDLE) ? i_addr[LANE_BITS-1:0] : lane_q;
    assign illegal  = ((i_funct3[1:0] == W_DOUBLE) && (XLEN == 32)) || (i_funct3 == 3'b111);

    asrv32_lsu_align #(.XLEN(XLEN)) u_align (
        .i_funct3     (a_funct3),
        .i_lane       (a_lane),
        .i_rs2        (i_rs2_data),
        .i_rdata      (mem.i_mem_rdata),
        .o_wmask      (a_wmask),
        .o_wdata      (a_wdata),
        .o_load_data  (a_load),
        .o_misaligned (a_mis)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        is_store_d  = is_store_q;
        funct3_d    = funct3_q;
        lane_d      = lane_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wmask_d = mem_wmask_q;
        busy_d      = busy_q;
        load_data_d = load_data_q;
        done_d      = 1'b0;
        mis_d       = 1'b0;
        ill_d       = 1'b0;
        tmo_d       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    is_store_d = i_is_store;
                    funct3_d   = i_funct3;
                    lane_d     = i_addr[LANE_BITS-1:0];
                    cnt_d      = 16'd0;
                    busy_d     = 1'b1;
                    if (illegal || a_mis) begin
                        state_d = ST_FAULT;
                        done_d  = 1'b1;
                        ill_d   = illegal;
                        mis_d   = ~illegal;
                    end else begin
                        state_d     = ST_REQ;
                        mem_req_d   = 1'b1;
                        mem_we_d    = i_is_store;
                        mem_addr_d  = {i_addr[XLEN-1:LANE_BITS], {LANE_BITS{1'b0}}};
                        mem_wdata_d = a_wdata;
                        mem_wmask_d = a_wmask;
                    end
                end
            end
            ST_REQ: begin
                // ack on the final counted cycle still completes successfully
                if (mem.i_mem_ack || (cnt_q == CNT_LAST)) begin
                    state_d   = ST_DONE;
                    done_d    = 1'b1;
                    tmo_d     = ~mem.i_mem_ack;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    cnt_d     = 16'd0;
                    if (mem.i_mem_ack && !is_store_q) begin
                        load_data_d = a_load;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 16'd0;
            is_store_q  <= 1'b0;
            funct3_q    <= 3'd0;
            lane_q      <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wmask_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            mis_q       <= 1'b0;
            ill_q       <= 1'b0;
            tmo_q       <= 1'b0;
            load_data_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            is_store_q  <= is_store_d;
            funct3_q    <= funct3_d;
            lane_q      <= lane_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wmask_q <= mem_wmask_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            mis_q       <= mis_d;
            ill_q       <= ill_d;
            tmo_q       <= tmo_d;
            load_data_q <= load_data_d;
        end
    end

    assign o_busy          = busy_q;
    assign o_done          = done_q;
    assign o_load_data     = load_data_q;
    assign o_misaligned    = mis_q;
    assign o_illegal       = ill_q;
    assign o_timeout       = tmo_q;
    assign mem.o_mem_req   = mem_req_q;
    assign mem.o_mem_we    = mem_we_q;
    assign mem.o_mem_addr  = mem_addr_q;
    assign mem.o_mem_wdata = mem_wdata_q;
    assign mem.o_mem_wmask = mem_wmask_q;

endmodule

// File: tb/tb_asrv32_lsu.sv
// tb/tb_asrv32_lsu.sv - randomized model-checked bench for the 32- and 64-bit LSU
module tb_asrv32_lsu;

    localparam int T = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, is_store, ack;
    logic [2:0]  f3;
    logic [63:0] addr, rs2, rdata;

    always #5 clk = ~clk;

    asrv32_lsu_if #(.XLEN(32)) m32 ();
    asrv32_lsu_if #(.XLEN(64)) m64 ();
    assign m32.i_mem_ack   = ack;
    assign m32.i_mem_rdata = rdata[31:0];
    assign m64.i_mem_ack   = ack;
    assign m64.i_mem_rdata = rdata;

    logic        busy32, done32, mis32, ill32, tmo32;
    logic [31:0] ld32;
    logic        busy64, done64, mis64, ill64, tmo64;
    logic [63:0] ld64;

    asrv32_lsu #(.XLEN(32), .TIMEOUT_CYCLES(T)) dut32 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_is_store(is_store),
        .i_funct3(f3), .i_addr(addr[31:0]), .i_rs2_data(rs2[31:0]),
        .o_busy(busy32), .o_done(done32), .o_load_data(ld32),
        .o_misaligned(mis32), .o_illegal(ill32), .o_timeout(tmo32), .mem(m32)
    );

    asrv32_lsu #(.XLEN(64), .TIMEOUT_CYCLES(T)) dut64 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_is_store(is_store),
        .i_funct3(f3), .i_addr(addr), .i_rs2_data(rs2),
        .o_busy(busy64), .o_done(done64), .o_load_data(ld64),
        .o_misaligned(mis64), .o_illegal(ill64), .o_timeout(tmo64), .mem(m64)
    );

    typedef struct {
        logic        st;
        logic [2:0]  f3;
        logic [63:0] addr;
        logic [63:0] rs2;
        logic [63:0] rdata;
        int          d;
    } txn_t;

    typedef struct {
        logic        busy, done, mis, ill, tmo, req, we, ld_upd;
        logic [63:0] maddr, wdata, ld;
        logic [7:0]  wmask;
    } exp_t;

    exp_t        e32, e64;
    logic [63:0] last32, last64;
    bit          chk_en;
    int          total, bad;

    function automatic void chk(string n, logic [63:0] a, logic [63:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h", n, a, e);
        end
    endfunction

    function automatic logic [63:0] extend_load(int x, logic [2:0] fn, int lane, logic [63:0] rd);
        logic [63:0] mx, v, m;
        int nb;
        mx = (x == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        nb = 8 << fn[1:0];
        m  = (nb == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << nb) - 64'd1);
        v  = ((rd & mx) >> (8 * lane)) & m;
        if (!fn[2] && (((v >> (nb - 1)) & 64'd1) != 0)) v = v | ~m;
        return v & mx;
    endfunction

    // Expected outputs in cycle c after the start edge (c=1 is the first cycle after it)
    function automatic exp_t model_cycle(int x, txn_t t, int c);
        exp_t e;
        logic [63:0] mx;
        int nb, size, lane, nreq;
        bit ill, mis, ok;
        e = '{default: '0};
        mx = (x == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        nb = x / 8;
        size = 1 << t.f3[1:0];
        lane = int'(t.addr % nb);
        ill = ((t.f3[1:0] == 2'b11) && (x == 32)) || (t.f3 == 3'b111);
        mis = !ill && ((t.addr % size) != 0);
        if (c < 1) return e;
        if (ill || mis) begin
            if (c == 1) begin
                e.busy = 1; e.done = 1; e.ill = ill; e.mis = mis;
            end
            return e;
        end
        ok = (t.d < T);
        nreq = ok ? t.d + 1 : T;
        if (c <= nreq) begin
            e.busy = 1; e.req = 1; e.we = t.st;
            e.maddr = (t.addr - (t.addr % nb)) & mx;
            e.wmask = 8'(((1 << size) - 1) << lane);
            e.wdata = (t.rs2 << (8 * lane)) & mx;
        end else if (c == nreq + 1) begin
            e.busy = 1; e.done = 1; e.tmo = !ok;
            if (ok && !t.st) begin
                e.ld_upd = 1;
                e.ld = extend_load(x, t.f3, lane, t.rdata);
            end
        end
        return e;
    endfunction

    task automatic set_exp(exp_t a, exp_t b);
        if (a.ld_upd) last32 = a.ld;
        if (b.ld_upd) last64 = b.ld;
        e32 = a; e32.ld = last32;
        e64 = b; e64.ld = last64;
    endtask

    always @(posedge clk) begin
        #1;
        if (chk_en) begin
            chk("d32.busy", busy32, e32.busy);
            chk("d32.done", done32, e32.done);
            chk("d32.mis", mis32, e32.mis);
            chk("d32.ill", ill32, e32.ill);
            chk("d32.tmo", tmo32, e32.tmo);
            chk("d32.req", m32.o_mem_req, e32.req);
            chk("d32.we", m32.o_mem_we, e32.we);
            chk("d32.ld", ld32, e32.ld);
            if (e32.req) begin
                chk("d32.addr", m32.o_mem_addr, e32.maddr);
                chk("d32.wdata", m32.o_mem_wdata, e32.wdata);
                chk("d32.wmask", m32.o_mem_wmask, e32.wmask);
            end
            chk("d64.busy", busy64, e64.busy);
            chk("d64.done", done64, e64.done);
            chk("d64.mis", mis64, e64.mis);
            chk("d64.ill", ill64, e64.ill);
            chk("d64.tmo", tmo64, e64.tmo);
            chk("d64.req", m64.o_mem_req, e64.req);
            chk("d64.we", m64.o_mem_we, e64.we);
            chk("d64.ld", ld64, e64.ld);
            if (e64.req) begin
                chk("d64.addr", m64.o_mem_addr, e64.maddr);
                chk("d64.wdata", m64.o_mem_wdata, e64.wdata);
                chk("d64.wmask", m64.o_mem_wmask, e64.wmask);
            end
        end
    end

    task automatic run_txn(txn_t t);
        exp_t c32, c64;
        @(negedge clk);
        start = 1; is_store = t.st; f3 = t.f3; addr = t.addr; rs2 = t.rs2;
        ack = 0; rdata = {$urandom, $urandom};
        set_exp(model_cycle(32, t, 1), model_cycle(64, t, 1));
        for (int c = 1; c < 40; c++) begin
            @(negedge clk);
            c32 = model_cycle(32, t, c);
            c64 = model_cycle(64, t, c);
            if (!c32.busy && !c64.busy && c > t.d + 1) begin
                start = 0;
                ack = 1'($urandom_range(0, 1));
                rdata = {$urandom, $urandom};
                set_exp(model_cycle(32, t, c + 1), model_cycle(64, t, c + 1));
                break;
            end
            // junk starts land only while both units are busy and must be ignored
            start = (c32.busy && c64.busy) ? ($urandom_range(0, 2) == 0) : 1'b0;
            if (start) begin
                is_store = 1'($urandom); f3 = 3'($urandom);
                addr = {$urandom, $urandom}; rs2 = {$urandom, $urandom};
            end
            ack = (c == t.d + 1);
            rdata = ack ? t.rdata : {$urandom, $urandom};
            set_exp(model_cycle(32, t, c + 1), model_cycle(64, t, c + 1));
        end
    endtask

    function automatic txn_t mk(logic st, logic [2:0] fn, logic [63:0] a, logic [63:0] r2,
                                logic [63:0] rd, int d);
        txn_t t;
        t.st = st; t.f3 = fn; t.addr = a; t.rs2 = r2; t.rdata = rd; t.d = d;
        return t;
    endfunction

    initial begin
        txn_t sb, lh, lhu, lwm, tmo, ack4, ld, t;
        exp_t x;
        total = 0; bad = 0;
        rst_n = 0; start = 0; is_store = 0; f3 = 0; addr = 0; rs2 = 0; rdata = 0; ack = 0;
        last32 = 0; last64 = 0;
        e32 = '{default: '0}; e64 = '{default: '0};
        chk_en = 1;

        sb   = mk(1, 3'b000, 64'h1003, 64'hAB, 64'h0, 0);
        lh   = mk(0, 3'b001, 64'h2002, 64'h0, 64'h8001_1234, 0);
        lhu  = mk(0, 3'b101, 64'h2002, 64'h0, 64'h8001_1234, 0);
        lwm  = mk(0, 3'b010, 64'h3001, 64'h0, 64'h0, 0);
        tmo  = mk(1, 3'b010, 64'h4000, 64'h1234_5678, 64'h0, 9);
        ack4 = mk(0, 3'b010, 64'h4004, 64'h0, 64'hCAFE_F00D, 3);
        ld   = mk(0, 3'b011, 64'h8, 64'h0, 64'h0123_4567_89AB_CDEF, 0);

        x = model_cycle(32, sb, 1);
        chk("pin.sb.addr", x.maddr, 64'h1000);
        chk("pin.sb.wmask", x.wmask, 8'b1000);
        chk("pin.sb.wdata", x.wdata, 64'hAB00_0000);
        x = model_cycle(32, sb, 2);
        chk("pin.sb.done", x.done, 1);
        chk("pin.lh", extend_load(32, 3'b001, 2, 64'h8001_1234), 64'hFFFF_8001);
        chk("pin.lhu", extend_load(32, 3'b101, 2, 64'h8001_1234), 64'h0000_8001);
        x = model_cycle(32, lwm, 1);
        chk("pin.lw.mis", {x.done, x.mis, x.req}, 3'b110);
        x = model_cycle(32, tmo, 4);
        chk("pin.tmo.req4", x.req, 1);
        x = model_cycle(32, tmo, 5);
        chk("pin.tmo.done", {x.done, x.tmo}, 2'b11);
        x = model_cycle(32, ack4, 5);
        chk("pin.ack4", {x.done, x.tmo}, 2'b10);
        x = model_cycle(64, ld, 2);
        chk("pin.ld", x.ld, 64'h0123_4567_89AB_CDEF);
        x = model_cycle(32, ld, 1);
        chk("pin.ld32.ill", {x.done, x.ill}, 2'b11);

        repeat (2) @(negedge clk);
        rst_n = 1;

        run_txn(sb);
        run_txn(lh);
        run_txn(lhu);
        run_txn(lwm);
        run_txn(tmo);
        run_txn(ack4);
        run_txn(ld);

        // asynchronous reset while a request is outstanding
        @(negedge clk);
        chk_en = 0;
        start = 1; is_store = 0; f3 = 3'b010; addr = 64'h40; ack = 0;
        @(negedge clk);
        start = 0;
        @(posedge clk);
        #1;
        chk("rst.pre.req32", m32.o_mem_req, 1);
        chk("rst.pre.req64", m64.o_mem_req, 1);
        #2;
        rst_n = 0;
        #1;
        chk("rst.req32", m32.o_mem_req, 0);
        chk("rst.busy32", busy32, 0);
        chk("rst.req64", m64.o_mem_req, 0);
        chk("rst.busy64", busy64, 0);
        chk("rst.done32", done32, 0);
        @(negedge clk);
        rst_n = 1;
        last32 = 0; last64 = 0;
        set_exp(model_cycle(32, sb, 0), model_cycle(64, sb, 0));
        chk_en = 1;
        run_txn(lh);

        for (int i = 0; i < 300; i++) begin
            t = mk(1'($urandom), 3'($urandom), {$urandom, $urandom}, {$urandom, $urandom},
                   {$urandom, $urandom}, $urandom_range(0, 6));
            if ($urandom_range(0, 2) != 0) t.addr = t.addr & ~64'h7 | 64'(8'(1 << t.f3[1:0]) & 8'h0);
            if ($urandom_range(0, 3) == 0) t.f3[1:0] = 2'b00;
            run_txn(t);
        end

        @(negedge clk);
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/asrv32_lsu.md
ASRV32_LSU -- requirements
Module: asrv32_lsu

Interface
REQ-001 Parameter XLEN, default 32, SHALL set data/address width; legal values 32 and 64.
REQ-002 Parameter TIMEOUT_CYCLES, default 255, SHALL set the maximum REQ-state cycles awaiting i_mem_ack; legal values 1..65535.
REQ-003 Parameter NBYTES = XLEN/8 SHALL be derived, not overridable; LANE_BITS = log2(NBYTES).
REQ-004 i_clk  in  1  sole clock; all state updates on rising edge.
REQ-005 i_rst_n  in  1  asynchronous, active-low reset.
REQ-006 i_start  in  1  one-cycle request to perform a load/store; ignored unless FSM is IDLE.
REQ-007 i_is_store  in  1  1 = store, 0 = load; sampled with i_start.
REQ-008 i_funct3  in  3  width/sign: [1:0] 00 byte, 01 half, 10 word, 11 double; [2] 1 = zero-extend load.
REQ-009 i_addr  in  XLEN  byte address; sampled with i_start.
REQ-010 i_rs2_data  in  XLEN  store data, right-aligned; sampled with i_start.
REQ-011 o_busy  out  1  high in every state except IDLE.
REQ-012 o_done  out  1  one-cycle completion pulse.
REQ-013 o_load_data  out  XLEN  extended load result; valid when o_done and load, held until next completion.
REQ-014 o_misaligned, o_illegal, o_timeout  out  1 each  fault flags; valid only with o_done.
REQ-015 o_mem_req  out  1  memory request, held until ack or timeout.
REQ-016 o_mem_we, o_mem_addr (XLEN), o_mem_wdata (XLEN), o_mem_wmask (NBYTES)  out  request attributes; stable while o_mem_req.
REQ-017 i_mem_ack  in  1  memory accepts/completes request; i_mem_rdata  in  XLEN  valid with ack for loads.

Function
REQ-018 FSM states SHALL be IDLE, REQ, DONE, FAULT.
REQ-019 IDLE + i_start, legal aligned access -> REQ; all request fields registered from inputs that edge.
REQ-020 IDLE + i_start with funct3=x11 and XLEN=32, or funct3=111 -> FAULT with o_illegal; no memory request.
REQ-021 IDLE + i_start, legal but address not aligned to access size (half: bit0; word: bits1:0; double: bits2:0) -> FAULT with o_misaligned; no memory request.
REQ-022 REQ: o_mem_req=1; i_mem_ack -> DONE; loads capture rdata that edge.
REQ-023 REQ: wait counter increments each cycle without ack; reaching TIMEOUT_CYCLES -> DONE with o_timeout=1, o_mem_req drops.
REQ-024 Ack on the cycle the counter reaches limit SHALL count as success (ack wins).
REQ-025 DONE and FAULT SHALL last exactly one cycle, assert o_done, then return to IDLE.
REQ-026 Minimum latency: i_start at cycle N, o_mem_req at N+1, ack at N+1, o_done at N+2; faults: o_done at N+1.
REQ-027 o_mem_addr = i_addr with low LANE_BITS cleared.
REQ-028 o_mem_wmask = size mask (1, 3, 0xF, 0xFF) shifted left by lane; o_mem_wdata = rs2 shifted left by 8*lane.
REQ-029 Load: rdata shifted right by 8*lane, truncated to size, sign- or zero-extended to XLEN per funct3[2].
REQ-030 o_mem_we = 1 only for stores, only while o_mem_req.
REQ-031 i_mem_ack outside REQ and i_start outside IDLE SHALL be ignored.

Reset
REQ-032 Reset SHALL force IDLE, counter 0, and every output to 0, immediately and asynchronously.
REQ-033 Reset during REQ SHALL drop o_mem_req the same cycle; no o_done pulse issued.

Structure
REQ-034 State encoding, funct3 width codes, and size-mask constants SHALL reside in the shared asrv32 header package.
REQ-035 One combinational sub-module asrv32_lsu_align SHALL compute wmask, wdata shift, load extract/extend and misalignment flag.

Verification
REQ-036 XLEN=32, SB rs2=0x000000AB, addr=0x1003, ack next cycle -> mem_addr 0x1000, wmask 1000, wdata 0xAB000000, o_done at N+2.
REQ-037 XLEN=32, LH addr=0x2002, rdata=0x8001_1234, ack -> o_load_data 0xFFFF8001; LHU -> 0x00008001.
REQ-038 LW addr=0x3001 -> o_done+o_misaligned at N+1, o_mem_req never high.
REQ-039 TIMEOUT_CYCLES=4, no ack -> o_mem_req high 4 cycles, then o_done+o_timeout; ack on 4th cycle -> success, no timeout.
REQ-040 XLEN=64, LD addr=0x8, rdata=0x0123456789ABCDEF -> load data equal; funct3=011 at XLEN=32 -> o_illegal.
REQ-041 Reset asserted mid-REQ -> o_mem_req, o_busy low immediately; subsequent i_start completes normally.
